// File: rtl/gremlin_pkg.sv
// rtl/gremlin_pkg.sv - shared widths and id-width helper for the gremlin ROM arbiter
package gremlin_pkg;

  localparam int FRAME_W = 3;
  localparam int LINE_W  = 5;
  localparam int PIX_W   = 16;

  // Requester index width; a single requester still needs a 1-bit id port.
  function automatic int gremlin_id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int GREMLIN_ID_W = gremlin_id_w(4);

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker starting at a supplied pointer
module rr_arbiter
  import gremlin_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = gremlin_id_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_idx,
  output logic             any
);

  logic [N_REQ-1:0] sel;
  logic             found;

  // Two passes: indices at or above ptr first, then the wrapped-around low indices.
  always_comb begin
    sel     = '0;
    found   = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && (i >= int'(ptr)) && req[i]) begin
        found   = 1'b1;
        sel[i]  = 1'b1;
        gnt_idx = ID_W'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[i]) begin
        found   = 1'b1;
        sel[i]  = 1'b1;
        gnt_idx = ID_W'(i);
      end
    end
    gnt = en ? sel : '0;
    any = en && found;
  end

endmodule

// File: rtl/gremlin_rom_arbiter.sv
// rtl/gremlin_rom_arbiter.sv - round-robin sharing of the gremlin sprite ROM with a 2-stage tagged pipeline
module gremlin_rom_arbiter
  import gremlin_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int FRAME_W = gremlin_pkg::FRAME_W,
  parameter int LINE_W  = gremlin_pkg::LINE_W,
  parameter int PIX_W   = gremlin_pkg::PIX_W,
  parameter int ID_W    = gremlin_id_w(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*FRAME_W-1:0] req_frame,
  input  logic [N_REQ*LINE_W-1:0]  req_line,
  output logic [N_REQ-1:0]         ack,
  output logic [FRAME_W-1:0]       rom_addr1,
  output logic [LINE_W-1:0]        rom_addr2,
  input  logic [PIX_W-1:0]         rom_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [PIX_W-1:0]         rsp_pixels
);

  logic               adv1, adv2;
  logic [N_REQ-1:0]   gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;

  logic               s1_valid_q, s1_valid_d;
  logic [ID_W-1:0]    s1_id_q, s1_id_d;
  logic [FRAME_W-1:0] addr1_q, addr1_d;
  logic [LINE_W-1:0]  addr2_q, addr2_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [PIX_W-1:0]   rsp_pixels_q, rsp_pixels_d;

  // Stage advance: S2 moves when empty or drained, S1 moves when empty or S2 moves.
  always_comb begin
    adv2 = !rsp_valid_q || rsp_ready;
    adv1 = !s1_valid_q || adv2;
  end

  // Grants are suppressed while reset is asserted so ack reads 0 immediately.
  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req     (req),
    .ptr     (rr_ptr_q),
    .en      (adv1 && rst_n),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  assign ack        = gnt;
  assign rom_addr1  = addr1_q;
  assign rom_addr2  = addr2_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_pixels = rsp_pixels_q;

  // S1: latch the granted requester's address and tag; pointer moves past the winner.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_id_d    = s1_id_q;
    addr1_d    = addr1_q;
    addr2_d    = addr2_q;
    rr_ptr_d   = rr_ptr_q;
    if (adv1) begin
      s1_valid_d = gnt_any;
      if (gnt_any) begin
        s1_id_d  = gnt_idx;
        rr_ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        for (int i = 0; i < N_REQ; i++) begin
          if (gnt[i]) begin
            addr1_d = req_frame[i*FRAME_W +: FRAME_W];
            addr2_d = req_line[i*LINE_W +: LINE_W];
          end
        end
      end
    end
  end

  // S2: capture ROM data for a valid S1 entry; a bubble only clears rsp_valid.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_pixels_d = rsp_pixels_q;
    if (adv2) begin
      rsp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        rsp_id_d     = s1_id_q;
        rsp_pixels_d = rom_data;
      end
    end
  end

  // Pipeline and pointer registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_id_q      <= '0;
      addr1_q      <= '0;
      addr2_q      <= '0;
      rr_ptr_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_pixels_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_id_q      <= s1_id_d;
      addr1_q      <= addr1_d;
      addr2_q      <= addr2_d;
      rr_ptr_q     <= rr_ptr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_pixels_q <= rsp_pixels_d;
    end
  end

endmodule
